carrier_loop_ctrl: RTL and testbench

Sequencer for the MPSK carrier-recovery loop. Consumes the 16-bit phase-error stream from the error detector (ErrDetecer output, signed Q1.14) and window-averages its magnitude. Steps the loop through acquisition, tracking and lock, selecting loop-filter gain shifts, clearing the NCO and reporting lock. Sits beside the error detector, driving the loop filter's gain inputs and the NCO clear.

---
 rtl/carrier_loop_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_carrier_loop_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/carrier_loop_ctrl.sv
// Carrier-recovery loop sequencer: window-averages |phase error| and steps the loop
// through IDLE -> ACQ -> TRACK -> LOCK, selecting filter gains and clearing the NCO.
module carrier_loop_ctrl #(
    parameter int DATA_WIDTH   = 16,
    parameter int WIN_LOG2     = 8,
    parameter int ACQ_KP_SHIFT = 4,
    parameter int ACQ_KI_SHIFT = 8,
    parameter int TRK_KP_SHIFT = 7,
    parameter int TRK_KI_SHIFT = 14,
    parameter int LOCK_CNT     = 4,
    parameter int UNLOCK_CNT   = 2,
    parameter int ACQ_TIMEOUT  = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    // ed_data is qualified by ed_valid alone (no back-pressure): every cycle with
    // ed_valid high outside IDLE contributes exactly one sample to the window.
    input  logic                  ed_valid,
    input  logic [DATA_WIDTH-1:0] ed_data,
    input  logic [DATA_WIDTH-1:0] th_lock,
    input  logic [DATA_WIDTH-1:0] th_unlock,
    output logic                  loop_en,
    output logic                  nco_clr,
    output logic [4:0]            kp_shift,
    output logic [4:0]            ki_shift,
    output logic                  lock,
    output logic [1:0]            state,
    output logic [DATA_WIDTH-1:0] err_mean,
    output logic                  mean_valid,
    output logic                  timeout
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACQ   = 2'd1;
    localparam logic [1:0] ST_TRACK = 2'd2;
    localparam logic [1:0] ST_LOCK  = 2'd3;

    localparam int AW = DATA_WIDTH + WIN_LOG2;
    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int BW = $clog2(UNLOCK_CNT + 1);
    localparam int TW = $clog2(ACQ_TIMEOUT + 1);

    localparam logic [DATA_WIDTH-1:0] MAG_MAX  = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] NEG_FULL = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [WIN_LOG2:0]     WIN_FULL = {1'b1, {WIN_LOG2{1'b0}}};

    logic [1:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] mag_q, mag_d;
    logic                  mag_vld_q, mag_vld_d;
    logic [AW-1:0]         acc_q, acc_d;
    logic [WIN_LOG2:0]     cnt_q, cnt_d;
    logic                  done_q, done_d;
    logic [DATA_WIDTH-1:0] mean_q, mean_d;
    logic                  mean_vld_q, mean_vld_d;
    logic [GW-1:0]         good_q, good_d, good_inc;
    logic [BW-1:0]         bad_q, bad_d, bad_inc;
    logic [TW-1:0]         tcnt_q, tcnt_d;
    logic                  nco_q, nco_d;
    logic                  timeout_q, timeout_d;
    logic                  loop_en_q, loop_en_d;
    logic                  lock_q, lock_d;
    logic [4:0]            kp_q, kp_d, ki_q, ki_d;
    logic                  restart, clear_pipe, trk_gain;

    always_comb begin
        good_inc  = (mean_q < th_lock)   ? good_q + 1'b1 : '0;
        bad_inc   = (mean_q > th_unlock) ? bad_q + 1'b1  : '0;
        state_d   = state_q;
        nco_d     = 1'b0;
        timeout_d = timeout_q;
        restart   = 1'b0;
        if (stop) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (start) begin
                    state_d   = ST_ACQ;
                    nco_d     = 1'b1;
                    timeout_d = 1'b0;
                end
                ST_ACQ: if (mean_vld_q) begin
                    if (good_inc == GW'(LOCK_CNT)) begin
                        state_d = ST_TRACK;
                    end else if (tcnt_q + 1'b1 == TW'(ACQ_TIMEOUT)) begin
                        // Stuck in acquisition: flush the NCO and start a fresh timeout period.
                        restart   = 1'b1;
                        nco_d     = 1'b1;
                        timeout_d = 1'b1;
                    end
                end
                ST_TRACK: if (mean_vld_q) begin
                    if (good_inc == GW'(LOCK_CNT)) begin
                        state_d = ST_LOCK;
                    end else if (bad_inc == BW'(UNLOCK_CNT)) begin
                        state_d = ST_ACQ;
                    end
                end
                ST_LOCK: if (mean_vld_q && bad_inc == BW'(UNLOCK_CNT)) begin
                    state_d = ST_ACQ;
                end
                default: state_d = ST_IDLE;
            endcase
        end
        clear_pipe = (state_d != state_q) || restart;

        good_d = good_q;
        bad_d  = bad_q;
        if (state_d != state_q) begin
            good_d = '0;
            bad_d  = '0;
        end else if (mean_vld_q) begin
            good_d = good_inc;
            bad_d  = bad_inc;
        end

        tcnt_d = tcnt_q;
        if (clear_pipe) begin
            tcnt_d = '0;
        end else if (mean_vld_q && state_q == ST_ACQ) begin
            tcnt_d = tcnt_q + 1'b1;
        end

        // The most negative code has no positive twin; clamp it to full scale.
        if (ed_data == NEG_FULL) begin
            mag_d = MAG_MAX;
        end else if (ed_data[DATA_WIDTH-1]) begin
            mag_d = ~ed_data + 1'b1;
        end else begin
            mag_d = ed_data;
        end
        mag_vld_d = ed_valid && (state_q != ST_IDLE) && !clear_pipe;

        acc_d = done_q ? '0 : acc_q;
        cnt_d = done_q ? '0 : cnt_q;
        if (mag_vld_q) begin
            acc_d = acc_d + {{WIN_LOG2{1'b0}}, mag_q};
            cnt_d = cnt_d + 1'b1;
        end
        done_d = mag_vld_q && (cnt_d == WIN_FULL);
        if (clear_pipe) begin
            acc_d  = '0;
            cnt_d  = '0;
            done_d = 1'b0;
        end

        mean_vld_d = done_q && !clear_pipe;
        mean_d     = mean_vld_d ? acc_q[AW-1:WIN_LOG2] : mean_q;

        trk_gain  = (state_d == ST_TRACK) || (state_d == ST_LOCK);
        kp_d      = trk_gain ? 5'(TRK_KP_SHIFT) : 5'(ACQ_KP_SHIFT);
        ki_d      = trk_gain ? 5'(TRK_KI_SHIFT) : 5'(ACQ_KI_SHIFT);
        loop_en_d = (state_d != ST_IDLE);
        lock_d    = (state_d == ST_LOCK);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            mag_q      <= '0;
            mag_vld_q  <= 1'b0;
            acc_q      <= '0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            mean_q     <= '0;
            mean_vld_q <= 1'b0;
            good_q     <= '0;
            bad_q      <= '0;
            tcnt_q     <= '0;
            nco_q      <= 1'b0;
            timeout_q  <= 1'b0;
            loop_en_q  <= 1'b0;
            lock_q     <= 1'b0;
            kp_q       <= 5'(ACQ_KP_SHIFT);
            ki_q       <= 5'(ACQ_KI_SHIFT);
        end else begin
            state_q    <= state_d;
            mag_q      <= mag_d;
            mag_vld_q  <= mag_vld_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            mean_q     <= mean_d;
            mean_vld_q <= mean_vld_d;
            good_q     <= good_d;
            bad_q      <= bad_d;
            tcnt_q     <= tcnt_d;
            nco_q      <= nco_d;
            timeout_q  <= timeout_d;
            loop_en_q  <= loop_en_d;
            lock_q     <= lock_d;
            kp_q       <= kp_d;
            ki_q       <= ki_d;
        end
    end

    assign loop_en    = loop_en_q;
    assign nco_clr    = nco_q;
    assign kp_shift   = kp_q;
    assign ki_shift   = ki_q;
    assign lock       = lock_q;
    assign state      = state_q;
    assign err_mean   = mean_q;
    assign mean_valid = mean_vld_q;
    assign timeout    = timeout_q;
endmodule

// File: tb/tb_carrier_loop_ctrl.sv
// Bench for carrier_loop_ctrl: two instances (long and short ACQ timeout) share one
// stimulus stream; expectations come from a window-level model of the loop rules.
module tb_carrier_loop_ctrl;
    localparam int DW   = 16;
    localparam int WL   = 4;
    localparam int NWIN = 1 << WL;

    logic          clk = 1'b0;
    logic          rst, start, stop, ed_valid;
    logic [DW-1:0] ed_data, th_lock, th_unlock;

    logic          loop_en[2], nco_clr[2], lock[2], mean_valid[2], timeout[2];
    logic [4:0]    kp_shift[2], ki_shift[2];
    logic [1:0]    state[2];
    logic [DW-1:0] err_mean[2];

    int n_tests = 0;
    int n_fail  = 0;

    // Model state per instance: index 0 = long timeout, 1 = short timeout.
    int to_lim[2] = '{64, 3};
    int m_st[2], m_g[2], m_b[2], m_t[2], m_to[2], m_nco[2];
    logic signed [DW-1:0] win[NWIN];

    carrier_loop_ctrl #(.WIN_LOG2(WL), .LOCK_CNT(4), .UNLOCK_CNT(2), .ACQ_TIMEOUT(64)) u_dut_a (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .ed_valid(ed_valid), .ed_data(ed_data),
        .th_lock(th_lock), .th_unlock(th_unlock), .loop_en(loop_en[0]), .nco_clr(nco_clr[0]),
        .kp_shift(kp_shift[0]), .ki_shift(ki_shift[0]), .lock(lock[0]), .state(state[0]),
        .err_mean(err_mean[0]), .mean_valid(mean_valid[0]), .timeout(timeout[0]));

    carrier_loop_ctrl #(.WIN_LOG2(WL), .LOCK_CNT(4), .UNLOCK_CNT(2), .ACQ_TIMEOUT(3)) u_dut_t (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .ed_valid(ed_valid), .ed_data(ed_data),
        .th_lock(th_lock), .th_unlock(th_unlock), .loop_en(loop_en[1]), .nco_clr(nco_clr[1]),
        .kp_shift(kp_shift[1]), .ki_shift(ki_shift[1]), .lock(lock[1]), .state(state[1]),
        .err_mean(err_mean[1]), .mean_valid(mean_valid[1]), .timeout(timeout[1]));

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed=no summary expected=summary before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int mag_of(input logic signed [DW-1:0] x);
        int v;
        v = int'(x);
        if (v == -32768) return 32767;
        return (v < 0) ? -v : v;
    endfunction

    function automatic int win_mean();
        int sum = 0;
        for (int i = 0; i < NWIN; i++) sum += mag_of(win[i]);
        return sum / NWIN;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_st[k] = 0; m_g[k] = 0; m_b[k] = 0; m_t[k] = 0; m_to[k] = 0; m_nco[k] = 0;
        end
    endtask

    task automatic model_mean(input int m);
        int nxt;
        for (int k = 0; k < 2; k++) begin
            m_nco[k] = 0;
            if (m_st[k] != 0) begin
                m_g[k] = (m < int'(th_lock))   ? m_g[k] + 1 : 0;
                m_b[k] = (m > int'(th_unlock)) ? m_b[k] + 1 : 0;
                nxt = m_st[k];
                if (m_st[k] == 1) begin
                    if (m_g[k] == 4) nxt = 2;
                    else begin
                        m_t[k]++;
                        if (m_t[k] == to_lim[k]) begin
                            m_to[k] = 1; m_nco[k] = 1; m_t[k] = 0;
                        end
                    end
                end else if (m_st[k] == 2) begin
                    if (m_g[k] == 4) nxt = 3;
                    else if (m_b[k] == 2) nxt = 1;
                end else if (m_b[k] == 2) begin
                    nxt = 1;
                end
                if (nxt != m_st[k]) begin
                    m_st[k] = nxt; m_g[k] = 0; m_b[k] = 0; m_t[k] = 0;
                end
            end
        end
    endtask

    task automatic check_ctrl(input string ph);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("%s.state%0d", ph, k), 32'(state[k]), 32'(m_st[k]));
            check($sformatf("%s.loop_en%0d", ph, k), 32'(loop_en[k]), 32'(m_st[k] != 0));
            check($sformatf("%s.lock%0d", ph, k), 32'(lock[k]), 32'(m_st[k] == 3));
            check($sformatf("%s.kp%0d", ph, k), 32'(kp_shift[k]), (m_st[k] >= 2) ? 32'd7 : 32'd4);
            check($sformatf("%s.ki%0d", ph, k), 32'(ki_shift[k]), (m_st[k] >= 2) ? 32'd14 : 32'd8);
            check($sformatf("%s.nco%0d", ph, k), 32'(nco_clr[k]), 32'(m_nco[k]));
            check($sformatf("%s.timeout%0d", ph, k), 32'(timeout[k]), 32'(m_to[k]));
        end
    endtask

    task automatic check_reset(input string ph);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("%s.state%0d", ph, k), 32'(state[k]), 32'd0);
            check($sformatf("%s.loop_en%0d", ph, k), 32'(loop_en[k]), 32'd0);
            check($sformatf("%s.nco%0d", ph, k), 32'(nco_clr[k]), 32'd0);
            check($sformatf("%s.kp%0d", ph, k), 32'(kp_shift[k]), 32'd4);
            check($sformatf("%s.ki%0d", ph, k), 32'(ki_shift[k]), 32'd8);
            check($sformatf("%s.lock%0d", ph, k), 32'(lock[k]), 32'd0);
            check($sformatf("%s.mean%0d", ph, k), 32'(err_mean[k]), 32'd0);
            check($sformatf("%s.mv%0d", ph, k), 32'(mean_valid[k]), 32'd0);
            check($sformatf("%s.timeout%0d", ph, k), 32'(timeout[k]), 32'd0);
        end
    endtask

    task automatic do_start(input string ph);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (m_st[k] == 0) begin
                m_st[k] = 1; m_nco[k] = 1; m_to[k] = 0; m_g[k] = 0; m_b[k] = 0; m_t[k] = 0;
            end
        end
        check_ctrl(ph);
        step();
        for (int k = 0; k < 2; k++) m_nco[k] = 0;
        check($sformatf("%s.nco_end0", ph), 32'(nco_clr[0]), 32'd0);
        check($sformatf("%s.nco_end1", ph), 32'(nco_clr[1]), 32'd0);
    endtask

    task automatic do_stop(input string ph);
        stop = 1'b1;
        step();
        stop = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_st[k] = 0; m_g[k] = 0; m_b[k] = 0; m_t[k] = 0; m_nco[k] = 0;
        end
        check_ctrl(ph);
    endtask

    task automatic fill_rand(input int lo, input int hi);
        int mg;
        for (int i = 0; i < NWIN; i++) begin
            mg = int'($urandom_range(hi, lo));
            win[i] = ($urandom_range(0, 1) == 1) ? 16'(-mg) : 16'(mg);
        end
    endtask

    task automatic send_window(input int gap_max);
        for (int i = 0; i < NWIN; i++) begin
            if (i > 0) begin
                ed_valid = 1'b0;
                repeat ($urandom_range(0, gap_max)) step();
            end
            ed_valid = 1'b1;
            ed_data  = win[i];
            step();
        end
        ed_valid = 1'b0;
    endtask

    // Last sample was taken at the edge just before this call.
    task automatic finish_window(input string ph);
        int m;
        m = win_mean();
        step();
        check({ph, ".mv_early"}, 32'(mean_valid[0]), 32'd0);
        step();
        check({ph, ".mv0"}, 32'(mean_valid[0]), 32'd1);
        check({ph, ".mv1"}, 32'(mean_valid[1]), 32'd1);
        check({ph, ".mean0"}, 32'(err_mean[0]), 32'(m));
        check({ph, ".mean1"}, 32'(err_mean[1]), 32'(m));
        model_mean(m);
        step();
        check({ph, ".mv_late"}, 32'(mean_valid[0]), 32'd0);
        check_ctrl(ph);
        step();
        for (int k = 0; k < 2; k++) m_nco[k] = 0;
        check({ph, ".nco_end0"}, 32'(nco_clr[0]), 32'd0);
        check({ph, ".nco_end1"}, 32'(nco_clr[1]), 32'd0);
    endtask

    task automatic do_window(input string ph, input int lo, input int hi, input int gap);
        fill_rand(lo, hi);
        send_window(gap);
        finish_window(ph);
    endtask

    initial begin
        int lo;
        rst = 1'b1; start = 1'b0; stop = 1'b0; ed_valid = 1'b0; ed_data = '0;
        th_lock = 16'h0400; th_unlock = 16'h0800;
        model_reset();
        repeat (3) step();
        check_reset("por");
        rst = 1'b0;
        step();

        // Window mean arithmetic: saturated full-scale negative, then alternating pattern.
        do_start("start1");
        for (int i = 0; i < NWIN; i++) win[i] = 16'sh8000;
        send_window(0);
        finish_window("sat");
        check("sat.value", 32'(err_mean[0]), 32'h7FFF);
        for (int i = 0; i < NWIN; i++) win[i] = (i % 2 == 0) ? 16'sh0100 : 16'shFD00;
        send_window(0);
        finish_window("alt");
        check("alt.value", 32'(err_mean[0]), 32'h0200);

        // Acquisition -> tracking -> lock with |ed| = 0x0100.
        do_stop("stop1");
        do_start("start2");
        for (int w = 0; w < 8; w++) begin
            do_window($sformatf("lockseq%0d", w), 16'h0100, 16'h0100, 2);
            if (w == 3) check("track_after4", 32'(state[0]), 32'd2);
        end
        check("in_lock.state", 32'(state[0]), 32'd3);
        check("in_lock.lock", 32'(lock[0]), 32'd1);

        // Equality with th_unlock is not bad; a good mean between bad ones resets the count.
        do_window("eq0", 16'h0800, 16'h0800, 1);
        do_window("eq1", 16'h0800, 16'h0800, 1);
        do_window("bad_a", 16'h0900, 16'h0900, 1);
        do_window("good_mid", 16'h0100, 16'h0100, 1);
        do_window("bad_b", 16'h0900, 16'h0900, 1);
        check("still_lock", 32'(state[0]), 32'd3);
        do_window("bad_c", 16'h0900, 16'h0900, 1);
        check("unlock.state", 32'(state[0]), 32'd1);
        check("unlock.nco", 32'(nco_clr[0]), 32'd0);

        // Random magnitudes straddling both thresholds.
        for (int w = 0; w < 12; w++) begin
            lo = int'($urandom_range(0, 16'h0C00));
            do_window($sformatf("rand%0d", w), lo, lo + int'($urandom_range(0, 16'h0400)),
                      int'($urandom_range(0, 3)));
        end

        // Asynchronous reset while locked.
        do_stop("stop2");
        do_start("start3");
        for (int w = 0; w < 8; w++) do_window($sformatf("relock%0d", w), 16'h0100, 16'h0100, 1);
        check("relock.state", 32'(state[0]), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        check_reset("rst_lock");
        model_reset();
        step();
        rst = 1'b0;
        step();
        do_start("start_after_rst");

        // Acquisition timeout on the short-timeout instance.
        for (int w = 0; w < 3; w++) do_window($sformatf("to%0d", w), 16'h2000, 16'h2000, 1);
        check("to.flag", 32'(timeout[1]), 32'd1);
        check("to.state", 32'(state[1]), 32'd1);
        check("to.flag_long", 32'(timeout[0]), 32'd0);
        do_stop("stop3");
        do_start("start4");
        check("to.cleared", 32'(timeout[1]), 32'd0);

        // stop dominates start in IDLE.
        do_stop("stop4");
        stop = 1'b1; start = 1'b1;
        step();
        stop = 1'b0; start = 1'b0;
        check_ctrl("stop_start");
        check("stop_start.state", 32'(state[0]), 32'd0);

        // stop on the mean_valid cycle that would advance TRACK -> LOCK.
        do_start("start5");
        for (int w = 0; w < 7; w++) do_window($sformatf("pre%0d", w), 16'h0100, 16'h0100, 1);
        check("pre.track", 32'(state[0]), 32'd2);
        fill_rand(16'h0100, 16'h0100);
        send_window(0);
        step();
        step();
        check("stop_mean.mv", 32'(mean_valid[0]), 32'd1);
        do_stop("stop_mean");
        check("stop_mean.state", 32'(state[0]), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
